mmpu_command_decoder: RTL and testbench
=======================================

MMPU_COMMAND_DECODER -- requirements
Module: mmpu_command_decoder

Interface
REQ-001 SHALL have parameter DEST_SIZE, default 10, dest address width.
REQ-002 SHALL have parameter SRC_SIZE, default 10, source/row address width.
REQ-003 SHALL have parameter XB_SIZE, default 16, column bound width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted this cycle when cmd_valid=1.
REQ-007 SHALL have port mMPU_command, input, 34 bits: encoded command word.
REQ-008 SHALL have port uop_valid, output, 1 bit: micro-op present.
REQ-009 SHALL have port uop_ready, input, 1 bit: crossbar accepts micro-op.
REQ-010 SHALL have port uop_col, output, 1 bit: 1 = column-wise op, 0 = row-wise op.
REQ-011 SHALL have port uop_has_dest, output, 1 bit: 1 = dest-addressed op (type 00).
REQ-012 SHALL have port uop_func, output, 2 bits: logic function code (type 01 only).
REQ-013 SHALL have port uop_index, output, XB_SIZE bits: current row/column index, zero-extended.
REQ-014 SHALL have ports uop_src1 and uop_src2, output, SRC_SIZE bits: source addresses.
REQ-015 SHALL have port uop_dest, output, DEST_SIZE bits: destination address.
REQ-016 SHALL have port busy, output, 1 bit: sequencer in EXEC.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on illegal or empty-range command.

Function
REQ-018 SHALL decode the type from bits[1:0]: 11 = column range, 10 = row range, 01 = logic op, 00 = dest op.
REQ-019 SHALL load col_start=[33:18] and col_end=[17:2] on type 11.
REQ-020 SHALL load row_start=[21:12] and row_end=[11:2] on type 10, ignoring bits[33:22].
REQ-021 SHALL extract for op types: src1=[11:2], src2=[21:12], col=[33]; func=[23:22] for type 01; dest=[31:22] for type 00, with func forced to 00.
REQ-022 SHALL implement two states, IDLE and EXEC, with cmd_ready=1 only in IDLE.
REQ-023 SHALL complete a range command in IDLE on handshake, with registers updated the next cycle and the state remaining IDLE.
REQ-024 SHALL, on an op-command handshake in IDLE, latch the fields, set idx=(col ? col_start : row_start), set limit=(col ? col_end : row_end), and go to EXEC with uop_valid=1 on the following cycle.
REQ-025 SHALL hold uop_valid=1 in EXEC with all uop_* outputs stable until uop_ready=1.
REQ-026 SHALL, on uop handshake with idx<limit, increment idx by 1 and remain in EXEC.
REQ-027 SHALL, on uop handshake with idx==limit, drop uop_valid and return to IDLE; a single-index range yields exactly one micro-op.
REQ-028 SHALL drop a type-01 command with func=11 (illegal) without generating micro-ops, pulse err, and stay in IDLE.
REQ-029 SHALL drop an op command whose start > end without generating micro-ops, pulse err, and stay in IDLE.
REQ-030 SHALL compare idx and limit at XB_SIZE bits, so a range ending at 2^XB_SIZE-1 terminates without wrap.
REQ-031 SHALL use the range register values in effect at acceptance; range registers cannot change during EXEC because cmd_ready=0.
REQ-032 SHALL drive busy=1 exactly when state==EXEC.
REQ-033 SHALL register all outputs.

Reset
REQ-034 SHALL, on rst=1 at any time including mid-EXEC, immediately force: state=IDLE; uop_valid, busy and err = 0; cmd_ready=1 after rst deasserts; range registers, idx, limit and all uop_* fields = 0.
REQ-035 SHALL lose any in-flight command on reset, with no further micro-ops issued.

Verification
REQ-036 SHALL cover: row range 3..5 (type 10), then type-00 op with col=0, dest=7, src1=1, src2=2, uop_ready=1 -> 3 micro-ops, index 3, 4, 5, dest=7, has_dest=1, then IDLE, cmd_ready=1.
REQ-037 SHALL cover: column range 0x0002..0x0003, then type-01 func=01, col=1, with uop_ready low for 4 cycles -> uop_valid held with index=2 unchanged; after ready, index 2 then 3.
REQ-038 SHALL cover: type-01 with func=11 -> err pulses 1 cycle, no uop_valid, cmd_ready stays 1.
REQ-039 SHALL cover: row range 9..4, then op command -> err pulse, zero micro-ops.
REQ-040 SHALL cover: column range 0xFFFE..0xFFFF, col op -> exactly 2 micro-ops, no wrap.
REQ-041 SHALL cover: rst asserted during the second micro-op of a 5-step op -> uop_valid=0 asynchronously, range registers=0, next command accepted normally.

Source files
------------

// File: rtl/mmpu_command_decoder.sv
// mmpu_command_decoder: decodes 34-bit mMPU commands into range updates or a
// sequence of per-index crossbar micro-ops (one per row/column in the range).
`default_nettype none

module mmpu_command_decoder #(
  parameter int DEST_SIZE = 10,
  parameter int SRC_SIZE  = 10,
  parameter int XB_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [33:0]          mMPU_command,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic                 uop_col,
  output logic                 uop_has_dest,
  output logic [1:0]           uop_func,
  output logic [XB_SIZE-1:0]   uop_index,
  output logic [SRC_SIZE-1:0]  uop_src1,
  output logic [SRC_SIZE-1:0]  uop_src2,
  output logic [DEST_SIZE-1:0] uop_dest,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t                state;
  logic [XB_SIZE-1:0]    col_start;
  logic [XB_SIZE-1:0]    col_end;
  logic [SRC_SIZE-1:0]   row_start;
  logic [SRC_SIZE-1:0]   row_end;
  logic [XB_SIZE-1:0]    limit;

  logic [1:0]            cmd_type;
  logic                  cmd_col;
  logic [1:0]            cmd_func;
  logic [XB_SIZE-1:0]    sel_start;
  logic [XB_SIZE-1:0]    sel_end;

  // The op's range is taken from the registers as they stand at acceptance.
  always_comb begin
    cmd_type  = mMPU_command[1:0];
    cmd_col   = mMPU_command[33];
    cmd_func  = mMPU_command[23:22];
    sel_start = cmd_col ? col_start : XB_SIZE'(row_start);
    sel_end   = cmd_col ? col_end   : XB_SIZE'(row_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      uop_valid    <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      col_start    <= '0;
      col_end      <= '0;
      row_start    <= '0;
      row_end      <= '0;
      limit        <= '0;
      uop_index    <= '0;
      uop_col      <= 1'b0;
      uop_has_dest <= 1'b0;
      uop_func     <= 2'b00;
      uop_src1     <= '0;
      uop_src2     <= '0;
      uop_dest     <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            unique case (cmd_type)
              2'b11: begin
                col_start <= mMPU_command[18 +: XB_SIZE];
                col_end   <= mMPU_command[2 +: XB_SIZE];
              end
              2'b10: begin
                row_start <= mMPU_command[12 +: SRC_SIZE];
                row_end   <= mMPU_command[2 +: SRC_SIZE];
              end
              default: begin
                if ((cmd_type == 2'b01 && cmd_func == 2'b11) || (sel_start > sel_end)) begin
                  err <= 1'b1;
                end else begin
                  uop_col      <= cmd_col;
                  uop_has_dest <= (cmd_type == 2'b00);
                  uop_func     <= (cmd_type == 2'b01) ? cmd_func : 2'b00;
                  uop_src1     <= mMPU_command[2 +: SRC_SIZE];
                  uop_src2     <= mMPU_command[12 +: SRC_SIZE];
                  uop_dest     <= (cmd_type == 2'b00) ? mMPU_command[22 +: DEST_SIZE] : '0;
                  uop_index    <= sel_start;
                  limit        <= sel_end;
                  uop_valid    <= 1'b1;
                  busy         <= 1'b1;
                  cmd_ready    <= 1'b0;
                  state        <= EXEC;
                end
              end
            endcase
          end
        end
        EXEC: begin
          if (uop_ready) begin
            // Equality ends the sequence, so a range ending at all-ones never wraps.
            if (uop_index < limit) begin
              uop_index <= uop_index + 1'b1;
            end else begin
              uop_valid <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmpu_command_decoder.sv
// Directed self-checking bench for mmpu_command_decoder.
`default_nettype none

module tb_mmpu_command_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [33:0] mMPU_command = '0;
  logic        uop_valid;
  logic        uop_ready = 1'b0;
  logic        uop_col;
  logic        uop_has_dest;
  logic [1:0]  uop_func;
  logic [15:0] uop_index;
  logic [9:0]  uop_src1;
  logic [9:0]  uop_src2;
  logic [9:0]  uop_dest;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  mmpu_command_decoder #(.DEST_SIZE(10), .SRC_SIZE(10), .XB_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .mMPU_command(mMPU_command),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_col(uop_col), .uop_has_dest(uop_has_dest), .uop_func(uop_func),
    .uop_index(uop_index), .uop_src1(uop_src1), .uop_src2(uop_src2),
    .uop_dest(uop_dest), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single cycle; returns #1 after the accepting edge.
  task automatic send(input logic [33:0] c);
    @(negedge clk);
    cmd_valid    = 1'b1;
    mMPU_command = c;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    mMPU_command = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uop_valid", 32'(uop_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_index", 32'(uop_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Row range 3..5, then dest op: indices 3,4,5
    uop_ready = 1'b1;
    send({12'd0, 10'd3, 10'd5, 2'b10});
    chk("row_rng_ready", 32'(cmd_ready), 32'd1);
    chk("row_rng_novalid", 32'(uop_valid), 32'd0);
    send({1'b0, 1'b0, 10'd7, 10'd2, 10'd1, 2'b00});
    chk("d_valid0", 32'(uop_valid), 32'd1);
    chk("d_busy", 32'(busy), 32'd1);
    chk("d_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("d_index0", 32'(uop_index), 32'd3);
    chk("d_dest", 32'(uop_dest), 32'd7);
    chk("d_has_dest", 32'(uop_has_dest), 32'd1);
    chk("d_src1", 32'(uop_src1), 32'd1);
    chk("d_src2", 32'(uop_src2), 32'd2);
    chk("d_col", 32'(uop_col), 32'd0);
    chk("d_func", 32'(uop_func), 32'd0);
    step();
    chk("d_index1", 32'(uop_index), 32'd4);
    chk("d_valid1", 32'(uop_valid), 32'd1);
    step();
    chk("d_index2", 32'(uop_index), 32'd5);
    chk("d_valid2", 32'(uop_valid), 32'd1);
    step();
    chk("d_done_valid", 32'(uop_valid), 32'd0);
    chk("d_done_busy", 32'(busy), 32'd0);
    chk("d_done_ready", 32'(cmd_ready), 32'd1);

    // Column range 2..3, logic op func=01 with back-pressure
    uop_ready = 1'b0;
    send({16'h0002, 16'h0003, 2'b11});
    send({1'b1, 9'd0, 2'b01, 10'd6, 10'd5, 2'b01});
    chk("l_valid0", 32'(uop_valid), 32'd1);
    chk("l_index0", 32'(uop_index), 32'd2);
    chk("l_func", 32'(uop_func), 32'd1);
    chk("l_col", 32'(uop_col), 32'd1);
    chk("l_has_dest", 32'(uop_has_dest), 32'd0);
    chk("l_src1", 32'(uop_src1), 32'd5);
    chk("l_src2", 32'(uop_src2), 32'd6);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("l_hold_valid", 32'(uop_valid), 32'd1);
      chk("l_hold_index", 32'(uop_index), 32'd2);
    end
    uop_ready = 1'b1;
    step();
    chk("l_index1", 32'(uop_index), 32'd3);
    chk("l_valid1", 32'(uop_valid), 32'd1);
    step();
    chk("l_done_valid", 32'(uop_valid), 32'd0);

    // Illegal func=11
    send({1'b0, 9'd0, 2'b11, 10'd0, 10'd0, 2'b01});
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_valid", 32'(uop_valid), 32'd0);
    chk("ill_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("ill_err_clear", 32'(err), 32'd0);
    chk("ill_valid2", 32'(uop_valid), 32'd0);

    // Empty row range 9..4
    send({12'd0, 10'd9, 10'd4, 2'b10});
    send({1'b0, 1'b0, 10'd1, 10'd0, 10'd0, 2'b00});
    chk("emp_err", 32'(err), 32'd1);
    chk("emp_valid", 32'(uop_valid), 32'd0);
    chk("emp_busy", 32'(busy), 32'd0);
    step();
    chk("emp_err_clear", 32'(err), 32'd0);
    chk("emp_valid2", 32'(uop_valid), 32'd0);

    // Column range at the top of the index space: no wrap
    send({16'hFFFE, 16'hFFFF, 2'b11});
    send({1'b1, 1'b0, 10'd3, 10'd0, 10'd0, 2'b00});
    chk("top_index0", 32'(uop_index), 32'hFFFE);
    chk("top_valid0", 32'(uop_valid), 32'd1);
    step();
    chk("top_index1", 32'(uop_index), 32'hFFFF);
    chk("top_valid1", 32'(uop_valid), 32'd1);
    step();
    chk("top_done_valid", 32'(uop_valid), 32'd0);
    chk("top_done_index", 32'(uop_index), 32'hFFFF);
    chk("top_done_ready", 32'(cmd_ready), 32'd1);

    // Reset during the second micro-op of a 5-step row op
    send({12'd0, 10'd10, 10'd14, 2'b10});
    send({1'b0, 1'b0, 10'd4, 10'd0, 10'd0, 2'b00});
    chk("r_index0", 32'(uop_index), 32'd10);
    step();
    chk("r_index1", 32'(uop_index), 32'd11);
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_valid", 32'(uop_valid), 32'd0);
    chk("r_async_busy", 32'(busy), 32'd0);
    chk("r_async_index", 32'(uop_index), 32'd0);
    chk("r_async_dest", 32'(uop_dest), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("r_ready_after", 32'(cmd_ready), 32'd1);
    chk("r_valid_after", 32'(uop_valid), 32'd0);
    // Ranges cleared by reset: row op covers index 0 only
    send({1'b0, 1'b0, 10'd9, 10'd0, 10'd0, 2'b00});
    chk("r_post_valid", 32'(uop_valid), 32'd1);
    chk("r_post_index", 32'(uop_index), 32'd0);
    chk("r_post_dest", 32'(uop_dest), 32'd9);
    step();
    chk("r_post_done", 32'(uop_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
